// File: rtl/sync_fifo_mon_pkg.sv
// sync_fifo_mon_pkg: error bit indices and error vector type for the FIFO monitor
package sync_fifo_mon_pkg;
    localparam int ERR_W      = 9;
    localparam int ERR_FULL   = 0;
    localparam int ERR_EMPTY  = 1;
    localparam int ERR_AFULL  = 2;
    localparam int ERR_AEMPTY = 3;
    localparam int ERR_OVF_M  = 4;
    localparam int ERR_UNF_M  = 5;
    localparam int ERR_OVF_S  = 6;
    localparam int ERR_UNF_S  = 7;
    localparam int ERR_DATA   = 8;
    typedef logic [ERR_W-1:0] err_vec_t;
endpackage

// File: rtl/sync_fifo_mon_model.sv
// sync_fifo_mon_model: shadow FIFO (storage, pointers, count) and expected read-data pipeline
module sync_fifo_mon_model #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [CW-1:0]    count,
    output logic             wa,
    output logic             ra,
    output logic             exp_valid,
    output logic [WIDTH-1:0] exp_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;

    // a write at full is still taken when a read frees a slot in the same cycle
    assign wa = wr_en && (count < DEPTH_C || rd_en);
    assign ra = rd_en && count != '0;

    // pointer and occupancy tracking of accepted transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wa) wptr <= wptr + AW'(1);
            if (ra) rptr <= rptr + AW'(1);
            count <= count + CW'(wa) - CW'(ra);
        end
    end

    // shadow storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (wa) mem[wptr] <= wdata;
    end

    if (RD_LAT == 0) begin : g_lat0
        assign exp_valid = ra;
        assign exp_data  = mem[rptr];
    end else begin : g_lat1
        // expected data follows the accepted read by one cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                exp_valid <= 1'b0;
                exp_data  <= '0;
            end else begin
                exp_valid <= ra;
                if (ra) exp_data <= mem[rptr];
            end
        end
    end
endmodule

// File: rtl/sync_fifo_monitor.sv
// sync_fifo_monitor: checks a synchronous FIFO's flags and read data against a shadow model
module sync_fifo_monitor
    import sync_fifo_mon_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         rdata,
    input  logic                     full,
    input  logic                     empty,
    input  logic                     almost_full,
    input  logic                     almost_empty,
    input  logic                     overflow,
    input  logic                     underflow,
    input  logic                     clr_err,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_valid,
    output logic [ERR_W-1:0]         err_flags,
    output logic [ERR_W-1:0]         err_sticky,
    output logic [CNT_W-1:0]         err_count,
    output logic [ERR_W-1:0]         first_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [CW-1:0]    count;
    logic             wa, ra, exp_valid, ovf_exp, unf_exp;
    logic [WIDTH-1:0] exp_data;
    err_vec_t         err_now;

    sync_fifo_mon_model #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT),
        .CW    (CW)
    ) u_model (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .count    (count),
        .wa       (wa),
        .ra       (ra),
        .exp_valid(exp_valid),
        .exp_data (exp_data)
    );

    assign occupancy = count;

    // every check uses the pre-update shadow count of the current cycle
    always_comb begin
        err_now             = '0;
        err_now[ERR_FULL]   = full != (count == DEPTH_C);
        err_now[ERR_EMPTY]  = empty != (count == '0);
        err_now[ERR_AFULL]  = almost_full != (count >= AF_C);
        err_now[ERR_AEMPTY] = almost_empty != (count <= AE_C);
        err_now[ERR_OVF_M]  = ovf_exp && !overflow;
        err_now[ERR_UNF_M]  = unf_exp && !underflow;
        err_now[ERR_OVF_S]  = overflow && !ovf_exp;
        err_now[ERR_UNF_S]  = underflow && !unf_exp;
        err_now[ERR_DATA]   = exp_valid && (rdata != exp_data);
    end

    // a rejected request must be answered by the DUT's flag on the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_exp <= 1'b0;
            unf_exp <= 1'b0;
        end else begin
            ovf_exp <= wr_en && !wa;
            unf_exp <= rd_en && !ra;
        end
    end

    // error reporting; a failure arriving with clr_err reloads the fields from itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid  <= 1'b0;
            err_flags  <= '0;
            err_sticky <= '0;
            err_count  <= '0;
            first_err  <= '0;
        end else begin
            err_valid <= |err_now;
            err_flags <= err_now;
            if (|err_now) begin
                err_sticky <= (clr_err ? '0 : err_sticky) | err_now;
                err_count  <= clr_err ? CNT_W'(1) : err_count + CNT_W'(!(&err_count));
                first_err  <= (clr_err || first_err == '0) ? err_now : first_err;
            end else if (clr_err) begin
                err_sticky <= '0;
                err_count  <= '0;
                first_err  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_monitor.sv
// tb_sync_fifo_monitor: drives a behavioural FIFO with injectable faults into the monitor and scoreboards its outputs
module tb_sync_fifo_monitor;
    typedef struct packed {
        logic [4:0]  occ;
        logic        v;
        logic [8:0]  f;
        logic [8:0]  s;
        logic [15:0] c;
        logic [8:0]  fe;
    } rec_t;

    logic        clk = 0, rst_n = 0;
    logic        wr_en = 0, rd_en = 0, clr_err = 0;
    logic        full = 0, empty = 0, almost_full = 0, almost_empty = 0, overflow = 0, underflow = 0;
    logic [7:0]  wdata = 0, rdata = 0;
    logic [4:0]  occupancy;
    logic        err_valid;
    logic [8:0]  err_flags, err_sticky, first_err;
    logic [15:0] err_count;

    int tests = 0, fails = 0;

    // behavioural FIFO standing in for the DUT, with fault knobs
    logic [7:0] bq[$];
    logic       ovf_p = 0, unf_p = 0;
    logic [7:0] rd_p = 0;
    logic [5:0] flt = 0;
    logic       ovr = 0;
    logic [7:0] ovr_val = 0;

    // reference model of the monitor
    logic [7:0] sq[$];
    logic       ovf_e = 0, unf_e = 0, pend_v = 0;
    logic [7:0] pend_d = 0;
    logic [8:0] m_s = 0, m_fe = 0;
    int         m_c = 0;
    rec_t       exp_q[$];

    sync_fifo_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .rdata       (rdata),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err),
        .occupancy   (occupancy),
        .err_valid   (err_valid),
        .err_flags   (err_flags),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .first_err   (first_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        logic [8:0] f;
        int         n;
        logic       wa, ra;
        if (!rst_n) begin
            sq.delete();
            ovf_e = 0; unf_e = 0; pend_v = 0; pend_d = 0;
            m_s = 0; m_c = 0; m_fe = 0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            n = sq.size();
            f = {pend_v && rdata != pend_d, underflow && !unf_e, overflow && !ovf_e,
                 unf_e && !underflow, ovf_e && !overflow, almost_empty != (n <= 2),
                 almost_full != (n >= 14), empty != (n == 0), full != (n == 16)};
            wa = wr_en && (n < 16 || rd_en);
            ra = rd_en && n > 0;
            pend_v = ra;
            if (ra) pend_d = sq.pop_front();
            if (wa) sq.push_back(wdata);
            ovf_e = wr_en && !wa;
            unf_e = rd_en && !ra;
            if (f != 0) begin
                m_s  = (clr_err ? 9'h0 : m_s) | f;
                m_c  = clr_err ? 1 : (m_c < 65535 ? m_c + 1 : m_c);
                m_fe = (clr_err || m_fe == 0) ? f : m_fe;
            end else if (clr_err) begin
                m_s = 0; m_c = 0; m_fe = 0;
            end
            exp_q.push_back('{occ: 5'(sq.size()), v: f != 0, f: f, s: m_s, c: 16'(m_c), fe: m_fe});
        end
    end

    always @(negedge clk) begin
        rec_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {occupancy, err_valid, err_flags, err_sticky, err_count, first_err};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle @%0t: occ %0d/%0d valid %b/%b flags %h/%h sticky %h/%h count %0d/%0d first %h/%h (got/required)",
                         $time, a.occ, e.occ, a.v, e.v, a.f, e.f, a.s, e.s, a.c, e.c, a.fe, e.fe);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        int   n;
        logic wacc, racc;
        n = bq.size();
        {full, empty, almost_full, almost_empty, overflow, underflow} =
            {n == 16, n == 0, n >= 14, n <= 2, ovf_p, unf_p} ^ flt;
        rdata = ovr ? ovr_val : rd_p;
        wr_en = w; wdata = d; rd_en = r;
        wacc = w && (n < 16 || r);
        racc = r && n > 0;
        ovf_p = w && !wacc;
        unf_p = r && !racc;
        if (racc) rd_p = bq.pop_front();
        if (wacc) bq.push_back(d);
        @(posedge clk); #1;
        flt = '0; ovr = 0; clr_err = 0;
    endtask

    initial begin
        int wp;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occ", 32'(occupancy), 0);
        chk("reset_sticky", 32'(err_sticky), 0);
        chk("reset_count", 32'(err_count), 0);
        rst_n = 1;

        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0);
        chk("fill_occ", 32'(occupancy), 16);
        repeat (16) drive(0, 0, 1);
        drive(0, 0, 0);
        chk("drain_occ", 32'(occupancy), 0);
        chk("drain_sticky", 32'(err_sticky), 0);
        chk("drain_count", 32'(err_count), 0);

        repeat (16) drive(1, 8'($urandom), 0);
        drive(1, 8'hEE, 0);
        drive(0, 0, 0);
        chk("ovf_ok_sticky", 32'(err_sticky), 0);
        drive(1, 8'hEE, 0);
        flt = 6'b000010;
        drive(0, 0, 0);
        chk("ovf_miss_flags", 32'(err_flags), 32'h010);
        chk("ovf_miss_count", 32'(err_count), 1);
        drive(0, 0, 0);
        chk("ovf_miss_pulse_end", 32'(err_valid), 0);

        clr_err = 1;
        drive(0, 0, 0);
        chk("clr_count", 32'(err_count), 0);
        repeat (16) drive(0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 8'(i), 0);
        repeat (4) drive(0, 0, 1);
        ovr = 1;
        ovr_val = 8'h5A;
        drive(0, 0, 0);
        chk("data_flags", 32'(err_flags), 32'h100);
        chk("data_first", 32'(first_err), 32'h100);

        repeat (16) drive(1, 8'($urandom), 0);
        clr_err = 1;
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            flt = 6'b100000;
            drive(0, 0, 0);
            chk("stuck_valid", 32'(err_valid), 1);
        end
        drive(0, 0, 0);
        chk("stuck_valid_end", 32'(err_valid), 0);
        chk("stuck_count", 32'(err_count), 3);
        chk("stuck_sticky", 32'(err_sticky), 32'h001);
        chk("stuck_first", 32'(first_err), 32'h001);
        clr_err = 1;
        drive(0, 0, 0);
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_count2", 32'(err_count), 0);
        chk("clr_first", 32'(first_err), 0);

        drive(1, 8'hAA, 1);
        chk("simul_full_occ", 32'(occupancy), 16);
        repeat (16) drive(0, 0, 1);
        chk("simul_drain_occ", 32'(occupancy), 0);
        drive(1, 8'hBB, 1);
        chk("simul_empty_occ", 32'(occupancy), 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("simul_sticky", 32'(err_sticky), 0);

        for (int i = 0; i < 600; i++) begin
            wp = i < 200 ? 80 : (i < 400 ? 20 : 50);
            if ($urandom_range(0, 29) == 0) flt = 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) begin
                ovr = 1;
                ovr_val = 8'($urandom);
            end
            clr_err = $urandom_range(0, 19) == 0;
            drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 100 - wp);
        end

        clr_err = 1;
        drive(0, 0, 0);
        repeat (16) drive(0, 0, 1);
        drive(0, 0, 0);
        repeat (7) drive(1, 8'($urandom), 0);
        chk("burst_occ", 32'(occupancy), 7);
        #2 rst_n = 0;
        #1;
        chk("async_rst_occ", 32'(occupancy), 0);
        chk("async_rst_count", 32'(err_count), 0);
        bq.delete();
        ovf_p = 0; unf_p = 0; rd_p = 0;
        wr_en = 0; rd_en = 0;
        @(posedge clk); #1;
        rst_n = 1;
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("post_rst_sticky", 32'(err_sticky), 0);
        chk("post_rst_occ", 32'(occupancy), 0);
        drive(0, 0, 0);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sync_fifo_monitor.md
Name: sync_fifo_monitor

Overview:
Synthesizable, parametrised, single-clock protocol and data-integrity monitor for a synchronous FIFO.
- Sits beside the FIFO DUT (bench or on-chip debug) and keeps a shadow model: occupancy, pointers and storage.
- Checks full, empty, almost_full, almost_empty, overflow, underflow and read data against that model every cycle.
- Reports errors as sticky flags, a saturating error counter and a first-error capture.

Parameters:
WIDTH, 8, data width of wdata/rdata.
DEPTH, 16, FIFO capacity in entries; power of two, 2..1024.
RD_LAT, 1, cycles from accepted rd_en to valid rdata; legal values 0 or 1.
AF_LVL, 14, almost_full expected when occupancy >= AF_LVL.
AE_LVL, 2, almost_empty expected when occupancy <= AE_LVL.
CNT_W, 16, error counter width.

Ports:
clk  input  1  monitor clock, same clock as the DUT FIFO
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  DUT write request
wdata  input  WIDTH  DUT write data
rd_en  input  1  DUT read request
rdata  input  WIDTH  DUT read data
full  input  1  DUT full flag
empty  input  1  DUT empty flag
almost_full  input  1  DUT almost-full flag
almost_empty  input  1  DUT almost-empty flag
overflow  input  1  DUT overflow flag
underflow  input  1  DUT underflow flag
clr_err  input  1  synchronous clear of sticky flags, counter and capture
occupancy  output  $clog2(DEPTH)+1  shadow entry count
err_valid  output  1  one-cycle pulse: at least one check failed in previous cycle
err_flags  output  9  checks failed in previous cycle (bit map below)
err_sticky  output  9  OR-accumulated err_flags
err_count  output  CNT_W  cycles with err_valid; saturates at all-ones
first_err  output  9  err_flags of first failing cycle since reset/clear

Behaviour:
- Reset (rst_n=0, async): all outputs 0; shadow pointers and count 0; read-compare pipeline invalid. Shadow storage is not reset.
- Reset mid-operation: model returns to empty immediately. The first check is evaluated on the first clk edge after deassertion.
- Accept rules:
  - wa = wr_en && (count<DEPTH || rd_en).
  - ra = rd_en && count>0.
  - Simultaneous read and write at full: both accepted, count unchanged.
  - Simultaneous at empty: write only, no fall-through.
- Count update: count += wa - ra. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Storage written at wptr on wa; expected data read at rptr on ra.
- Flag checks use the registered pre-update count, compared against DUT flags in the same cycle:
  - bit0 FULL: full != (count==DEPTH).
  - bit1 EMPTY: empty != (count==0).
  - bit2 AFULL: almost_full != (count>=AF_LVL).
  - bit3 AEMPTY: almost_empty != (count<=AE_LVL).
- Overflow/underflow: rejected write (wr_en && !wa) arms ovf_exp for the next cycle; rejected read (rd_en && !ra) arms unf_exp.
  - bit4 OVF_MISS: ovf_exp && !overflow.
  - bit5 UNF_MISS: unf_exp && !underflow.
  - bit6 OVF_SPUR: overflow && !ovf_exp.
  - bit7 UNF_SPUR: underflow && !unf_exp.
- Data check, bit8 DATA:
  - RD_LAT=0: compare rdata with mem[rptr] in the ra cycle.
  - RD_LAT=1: register expected data and valid on ra; compare on the next cycle.
- Output timing: err_flags and err_valid are registered, one cycle after the failing cycle. err_sticky, err_count and first_err update in that same cycle.
- clr_err: zeroes err_sticky, err_count and first_err. It does not touch the shadow model. If a failure reports in the same cycle as clr_err, the failure wins: fields load fresh from it.

Decomposition:
- Package sync_fifo_mon_pkg: error bit-index localparams (ERR_FULL .. ERR_DATA), ERR_W=9, and a typedef err_vec_t.
- Sub-module sync_fifo_mon_model: shadow storage, pointers, count, wa/ra and the expected-data pipeline.
- Top module: checks and error bookkeeping.

Test Plan:
- Write 16 words 0x00..0x0F, then read 16 (correct DUT) -> occupancy 16 then 0; err_sticky==0; err_count==0.
- Write at full (count 16, no rd_en); DUT raises overflow next cycle -> no error. DUT does not raise overflow -> err_flags==0x010 one cycle later and err_count==1.
- DUT returns 0x5A where 0x03 is expected (RD_LAT=1) -> err_flags bit8 two cycles after rd_en; first_err==0x100.
- DUT full stuck 0 at count 16 for 3 cycles -> err_valid for 3 cycles; err_count==3; err_sticky==0x001. clr_err then -> all error fields 0.
- Simultaneous wr_en and rd_en at count 16, then at count 0 -> count stays 16; then count goes 0->1; no overflow or underflow expected.
- rst_n pulsed low at count 7 mid-burst -> occupancy 0 asynchronously; the next read at empty expects underflow.
